// File: rtl/pipeline_control_fsm.sv
// Pipeline sequencer: merges hazard stalls, memory-busy, branch redirects and HLT into
// per-stage enables and bubble/flush controls, runs the halt FSM and keeps perf counters.
module pipeline_control_fsm #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             br_stall,
   input  logic             lu_stall,
   input  logic             ID_branch_taken,
   input  logic             ID_hlt,
   input  logic             WB_hlt,
   input  logic             imem_busy,
   input  logic             dmem_busy,
   output logic             PC_en,
   output logic             IF_ID_en,
   output logic             ID_EX_en,
   output logic             EX_MEM_en,
   output logic             MEM_WB_en,
   output logic             IF_ID_flush,
   output logic             ID_EX_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   branch_flush;
   logic   stall_event;

   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Rows are evaluated highest priority first; the first match wins.
   always_comb begin
      state_nxt    = state;
      PC_en        = 1'b0;
      IF_ID_en     = 1'b0;
      ID_EX_en     = 1'b0;
      EX_MEM_en    = 1'b0;
      MEM_WB_en    = 1'b0;
      IF_ID_flush  = 1'b0;
      ID_EX_flush  = 1'b0;
      halted       = 1'b0;
      branch_flush = 1'b0;
      if (!rst_n) begin
         state_nxt = RUN;
      end else if (state == HALTED) begin
         halted = 1'b1;
      end else if (dmem_busy) begin
         state_nxt = state;
      end else if (state == RUN && (br_stall || lu_stall)) begin
         ID_EX_en    = 1'b1;
         EX_MEM_en   = 1'b1;
         MEM_WB_en   = 1'b1;
         ID_EX_flush = 1'b1;
      end else if (state == RUN && ID_branch_taken) begin
         PC_en        = 1'b1;
         IF_ID_en     = 1'b1;
         ID_EX_en     = 1'b1;
         EX_MEM_en    = 1'b1;
         MEM_WB_en    = 1'b1;
         IF_ID_flush  = 1'b1;
         branch_flush = 1'b1;
      end else if (state == RUN && (ID_hlt || imem_busy)) begin
         // HLT and an instruction-memory miss share the same controls; only HLT drains.
         IF_ID_en    = 1'b1;
         ID_EX_en    = 1'b1;
         EX_MEM_en   = 1'b1;
         MEM_WB_en   = 1'b1;
         IF_ID_flush = 1'b1;
         if (ID_hlt) state_nxt = DRAIN;
      end else if (state == DRAIN) begin
         IF_ID_en    = 1'b1;
         ID_EX_en    = 1'b1;
         EX_MEM_en   = 1'b1;
         MEM_WB_en   = 1'b1;
         IF_ID_flush = 1'b1;
         if (WB_hlt) state_nxt = HALTED;
      end else begin
         PC_en     = 1'b1;
         IF_ID_en  = 1'b1;
         ID_EX_en  = 1'b1;
         EX_MEM_en = 1'b1;
         MEM_WB_en = 1'b1;
      end
   end

   assign stall_event = (state == RUN) && !PC_en;

   // Counters saturate at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (stall_event && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + 1'b1;
         if (branch_flush && (flush_count != {CNT_W{1'b1}}))
            flush_count <= flush_count + 1'b1;
      end
   end

endmodule
